lcd_show_char: RTL and testbench

- Glyph renderer directly downstream of the string/number control stage.
- On a start pulse it latches the character code, the start coordinate and the font size, then reads the glyph rows from the font ROM.
- It emits one RGB565 pixel write per glyph pixel over a valid/ready interface to the LCD write engine.
- It pulses show_char_done after each glyph, waits for the upstream registers to advance, then renders the next character until CHAR_NUM glyphs are drawn.

---
 rtl/lcd_show_char_if.sv | 11 +
 rtl/lcd_show_char.sv | 186 ++++++++++++++++++
 tb/tb_lcd_show_char.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_show_char_if.sv
// rtl/lcd_show_char_if.sv - pixel write bus between the glyph renderer and the LCD write engine
interface lcd_show_char_if;
  logic        wr_req;
  logic        wr_ready;
  logic [8:0]  wr_x;
  logic [8:0]  wr_y;
  logic [15:0] wr_color;

  modport master (output wr_req, wr_x, wr_y, wr_color, input wr_ready);
  modport slave  (input wr_req, wr_x, wr_y, wr_color, output wr_ready);
endinterface

// File: rtl/lcd_show_char.sv
// rtl/lcd_show_char.sv - renders CHAR_NUM glyphs from the font ROM as RGB565 pixel writes
module lcd_show_char #(
  parameter int unsigned CHAR_NUM    = 66,
  parameter logic [15:0] FG_COLOR    = 16'hFFFF,
  parameter logic [15:0] BG_COLOR    = 16'h0000,
  parameter int unsigned FONT12_BASE = 1520,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            show_char_flag,
  input  logic            en_size,
  input  logic [6:0]      ascii_num,
  input  logic [8:0]      start_x,
  input  logic [8:0]      start_y,
  output logic [10:0]     rom_addr,
  input  logic [7:0]      rom_data,
  lcd_show_char_if.master wr,
  output logic            show_char_done,
  output logic            busy
);

  localparam int CW = $clog2(CHAR_NUM + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_FETCH, S_ROMWAIT, S_PIXEL, S_DONE, S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic [6:0]  ascii_q, ascii_d;
  logic [8:0]  x0_q, x0_d;
  logic [8:0]  y0_q, y0_d;
  logic        size_q, size_d;
  logic [3:0]  last_row_q, last_row_d;
  logic [2:0]  last_col_q, last_col_d;
  logic [3:0]  row_q, row_d;
  logic [2:0]  col_q, col_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [10:0] rom_addr_q, rom_addr_d;
  logic [CW-1:0] glyph_q, glyph_d;
  logic [GW-1:0] gap_q, gap_d;

  // Word address of one glyph row; the 6x12 table sits above the 8x16 one.
  function automatic logic [10:0] font_addr(input logic size, input logic [6:0] code,
                                            input logic [3:0] row);
    logic [11:0] a;
    if (size) a = {1'b0, code, 4'b0000} + {8'd0, row};
    else      a = 12'(FONT12_BASE) + 12'(code) * 12'd12 + {8'd0, row};
    return a[10:0];
  endfunction

  always_comb begin
    state_d        = state_q;
    busy_d         = busy_q;
    ascii_d        = ascii_q;
    x0_d           = x0_q;
    y0_d           = y0_q;
    size_d         = size_q;
    last_row_d     = last_row_q;
    last_col_d     = last_col_q;
    row_d          = row_q;
    col_d          = col_q;
    shreg_d        = shreg_q;
    rom_addr_d     = rom_addr_q;
    glyph_d        = glyph_q;
    gap_d          = gap_q;
    show_char_done = 1'b0;
    wr.wr_req      = 1'b0;
    wr.wr_x        = 9'd0;
    wr.wr_y        = 9'd0;
    wr.wr_color    = 16'd0;

    case (state_q)
      S_IDLE: begin
        if (show_char_flag) begin
          state_d = S_LATCH;
          busy_d  = 1'b1;
        end
      end
      S_LATCH: begin
        ascii_d    = ascii_num;
        x0_d       = start_x;
        y0_d       = start_y;
        size_d     = en_size;
        last_row_d = en_size ? 4'd15 : 4'd11;
        last_col_d = en_size ? 3'd7 : 3'd5;
        row_d      = 4'd0;
        col_d      = 3'd0;
        rom_addr_d = font_addr(en_size, ascii_num, 4'd0);
        state_d    = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_ROMWAIT;
      end
      S_ROMWAIT: begin
        // Codes past '~' have no glyph in the table; draw them blank.
        shreg_d = (ascii_q > 7'd94) ? 8'h00 : rom_data;
        state_d = S_PIXEL;
      end
      S_PIXEL: begin
        wr.wr_req   = 1'b1;
        wr.wr_x     = x0_q + {6'd0, col_q};
        wr.wr_y     = y0_q + {5'd0, row_q};
        wr.wr_color = shreg_q[7] ? FG_COLOR : BG_COLOR;
        if (wr.wr_ready) begin
          if (col_q != last_col_q) begin
            col_d   = col_q + 3'd1;
            shreg_d = {shreg_q[6:0], 1'b0};
          end else begin
            col_d = 3'd0;
            if (row_q != last_row_q) begin
              row_d      = row_q + 4'd1;
              rom_addr_d = font_addr(size_q, ascii_q, row_q + 4'd1);
              state_d    = S_FETCH;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        show_char_done = 1'b1;
        glyph_d        = glyph_q + CW'(1);
        gap_d          = '0;
        state_d        = S_GAP;
      end
      S_GAP: begin
        // Upstream needs these cycles to present the next code and position.
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          if (glyph_q == CW'(CHAR_NUM)) begin
            glyph_d = '0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_LATCH;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      ascii_q    <= 7'd0;
      x0_q       <= 9'd0;
      y0_q       <= 9'd0;
      size_q     <= 1'b0;
      last_row_q <= 4'd0;
      last_col_q <= 3'd0;
      row_q      <= 4'd0;
      col_q      <= 3'd0;
      shreg_q    <= 8'd0;
      rom_addr_q <= 11'd0;
      glyph_q    <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      ascii_q    <= ascii_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      size_q     <= size_d;
      last_row_q <= last_row_d;
      last_col_q <= last_col_d;
      row_q      <= row_d;
      col_q      <= col_d;
      shreg_q    <= shreg_d;
      rom_addr_q <= rom_addr_d;
      glyph_q    <= glyph_d;
      gap_q      <= gap_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_lcd_show_char.sv
// tb/tb_lcd_show_char.sv - randomized bench for lcd_show_char against a glyph-level model
module tb_lcd_show_char;
  localparam int NG = 3;
  localparam logic [15:0] FG = 16'hFFFF;
  localparam logic [15:0] BG = 16'h0000;

  typedef struct packed { logic [8:0] x; logic [8:0] y; logic [15:0] c; } px_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flag, en_size;
  logic [6:0]  ascii;
  logic [8:0]  sx, sy;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        done, busy;
  lcd_show_char_if wr_bus();

  lcd_show_char #(.CHAR_NUM(NG)) dut (
    .sys_clk(clk), .sys_rst(rst), .show_char_flag(flag), .en_size(en_size),
    .ascii_num(ascii), .start_x(sx), .start_y(sy), .rom_addr(rom_addr),
    .rom_data(rom_data), .wr(wr_bus), .show_char_done(done), .busy(busy)
  );

  logic [7:0] rom [0:2047];
  always @(posedge clk) rom_data <= rom[rom_addr];

  px_t         mon_px[$], exp_px[$];
  logic [10:0] mon_addr[$], exp_addr[$];
  int          done_px[$];
  int          cyc, acc_cyc, done_cnt, stall_err, lat_err, dbl_err;
  int          ready_pct = 100;
  bit          prev_stall, prev_done;
  px_t         prev_px;
  logic [10:0] prev_addr = '0;

  int          checks, failures;
  bit          g_size[NG];
  logic [6:0]  g_ascii[NG];
  logic [8:0]  g_x[NG], g_y[NG];
  int          px_base, addr_base, done_base, stall_base, lat_base, dbl_base;
  logic [10:0] exp_last_addr;
  bit          tmo;
  logic [2:0]  bseq;

  // LCD-side monitor: drives wr_ready and records what was accepted.
  always @(negedge clk) begin
    cyc++;
    wr_bus.wr_ready = (ready_pct >= 100) || ($urandom_range(0, 99) < ready_pct);
    if (prev_stall && (!wr_bus.wr_req || {wr_bus.wr_x, wr_bus.wr_y, wr_bus.wr_color} !== prev_px))
      stall_err++;
    prev_stall = wr_bus.wr_req && !wr_bus.wr_ready;
    prev_px    = {wr_bus.wr_x, wr_bus.wr_y, wr_bus.wr_color};
    if (wr_bus.wr_req && wr_bus.wr_ready) begin
      mon_px.push_back({wr_bus.wr_x, wr_bus.wr_y, wr_bus.wr_color});
      acc_cyc = cyc;
    end
    if (busy === 1'b1 && rom_addr !== prev_addr) mon_addr.push_back(rom_addr);
    prev_addr = rom_addr;
    if (done === 1'b1) begin
      done_cnt++;
      done_px.push_back(mon_px.size());
      if (acc_cyc != cyc - 1) lat_err++;
      if (prev_done) dbl_err++;
    end
    prev_done = (done === 1'b1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required earlier completion");
    $fatal(1);
  end

  task automatic set_rand(input int k, input int sz, input int amax);
    g_size[k]  = (sz < 0) ? 1'($urandom_range(0, 1)) : 1'(sz);
    g_ascii[k] = 7'($urandom_range(0, amax));
    g_x[k]     = 9'($urandom_range(0, 511));
    g_y[k]     = 9'($urandom_range(0, 511));
  endtask

  task automatic apply(input int k);
    en_size = g_size[k]; ascii = g_ascii[k]; sx = g_x[k]; sy = g_y[k];
  endtask

  task automatic scramble();
    en_size = 1'($urandom_range(0, 1)); ascii = 7'($urandom);
    sx = 9'($urandom); sy = 9'($urandom);
  endtask

  // Expected pixels and distinct ROM addresses for the whole frame.
  task automatic build_model();
    logic [10:0] prev;
    prev = exp_last_addr;
    exp_px.delete();
    exp_addr.delete();
    for (int k = 0; k < NG; k++) begin
      int rows, cols;
      rows = g_size[k] ? 16 : 12;
      cols = g_size[k] ? 8 : 6;
      for (int r = 0; r < rows; r++) begin
        int a;
        logic [7:0] bits;
        a = g_size[k] ? int'(g_ascii[k]) * 16 + r : 1520 + int'(g_ascii[k]) * 12 + r;
        a = a % 2048;
        if (11'(a) != prev) exp_addr.push_back(11'(a));
        prev = 11'(a);
        bits = (g_ascii[k] > 94) ? 8'h00 : rom[a];
        for (int c = 0; c < cols; c++) begin
          px_t p;
          p.x = 9'((int'(g_x[k]) + c) % 512);
          p.y = 9'((int'(g_y[k]) + r) % 512);
          p.c = bits[7 - c] ? FG : BG;
          exp_px.push_back(p);
        end
      end
    end
    exp_last_addr = prev;
  endtask

  function automatic int px_bad();
    int n;
    n = (mon_px.size() - px_base != exp_px.size()) ? 1 : 0;
    for (int i = 0; i < exp_px.size() && px_base + i < mon_px.size(); i++)
      if (mon_px[px_base + i] !== exp_px[i]) n++;
    return n;
  endfunction

  function automatic int addr_bad();
    int n;
    n = (mon_addr.size() - addr_base != exp_addr.size()) ? 1 : 0;
    for (int i = 0; i < exp_addr.size() && addr_base + i < mon_addr.size(); i++)
      if (mon_addr[addr_base + i] !== exp_addr[i]) n++;
    return n;
  endfunction

  // Plays the upstream stage: starts a frame and advances code/position after each done.
  task automatic run_frame(input int pct, input bit extra_flag);
    ready_pct = pct;
    build_model();
    px_base = mon_px.size(); addr_base = mon_addr.size(); done_base = done_cnt;
    stall_base = stall_err; lat_base = lat_err; dbl_base = dbl_err;
    tmo = 0; bseq = 3'b000;
    @(negedge clk); apply(0); flag = 1'b1;
    @(negedge clk); flag = 1'b0;
    @(negedge clk); scramble(); if (extra_flag) flag = 1'b1;
    @(negedge clk); flag = 1'b0;
    for (int k = 0; k < NG; k++) begin
      int t;
      t = 0;
      while (done !== 1'b1 && t < 6000) begin @(negedge clk); t++; end
      if (t >= 6000) begin tmo = 1; break; end
      if (k < NG - 1) begin
        repeat (2) @(negedge clk);
        apply(k + 1);
        repeat (2) @(negedge clk);
        scramble();
      end else begin
        for (int i = 2; i >= 0; i--) begin @(negedge clk); bseq[i] = busy; end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flag = 1'b0; en_size = 1'b0; ascii = '0; sx = '0; sy = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_bus.wr_req, done, busy} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl: req/done/busy=%b required 000", {wr_bus.wr_req, done, busy});
    end
    checks++;
    if (rom_addr !== 11'd0) begin
      failures++; $display("FAIL reset_addr: rom_addr=%0d required 0", rom_addr);
    end
    checks++;
    if ({wr_bus.wr_x, wr_bus.wr_y, wr_bus.wr_color} !== 34'd0) begin
      failures++; $display("FAIL reset_pixel: x=%0d y=%0d c=%h required 0", wr_bus.wr_x, wr_bus.wr_y, wr_bus.wr_color);
    end
    rst = 1'b0; exp_last_addr = '0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: busy=%b required 0", busy); end
  endtask

  task automatic test_font16();
    g_size[0] = 1'b1; g_ascii[0] = 7'd16; g_x[0] = 9'd32; g_y[0] = 9'd48;
    set_rand(1, 1, 94); set_rand(2, 1, 94);
    run_frame(100, 1'b0);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL f16_timeout: timed out=%b required 0", tmo); end
    checks++;
    if (mon_px.size() - px_base != 3 * 128) begin
      failures++; $display("FAIL f16_count: writes=%0d required %0d", mon_px.size() - px_base, 3 * 128);
    end
    checks++; if (px_bad() != 0) begin failures++; $display("FAIL f16_pixels: bad=%0d required 0", px_bad()); end
    checks++; if (addr_bad() != 0) begin failures++; $display("FAIL f16_addr: bad=%0d required 0", addr_bad()); end
    checks++;
    if (mon_addr.size() < addr_base + 16 || mon_addr[addr_base] !== 11'd256 || mon_addr[addr_base + 15] !== 11'd271) begin
      failures++; $display("FAIL f16_addr_range: first=%0d last=%0d required 256..271", mon_addr[addr_base], mon_addr[addr_base + 15]);
    end
    checks++; if (done_cnt - done_base != 3) begin failures++; $display("FAIL f16_done: pulses=%0d required 3", done_cnt - done_base); end
    checks++; if (bseq !== 3'b110) begin failures++; $display("FAIL f16_busy_fall: busy seq=%b required 110", bseq); end
    checks++; if (lat_err != lat_base) begin failures++; $display("FAIL f16_done_latency: late=%0d required 0", lat_err - lat_base); end
  endtask

  task automatic test_font12();
    g_size[0] = 1'b0; g_ascii[0] = 7'd33; g_x[0] = 9'd0; g_y[0] = 9'd0;
    set_rand(1, 0, 94); set_rand(2, 0, 94);
    run_frame(100, 1'b0);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL f12_timeout: timed out=%b required 0", tmo); end
    checks++;
    if (mon_px.size() - px_base != 3 * 72) begin
      failures++; $display("FAIL f12_count: writes=%0d required %0d", mon_px.size() - px_base, 3 * 72);
    end
    checks++; if (px_bad() != 0) begin failures++; $display("FAIL f12_pixels: bad=%0d required 0", px_bad()); end
    checks++; if (addr_bad() != 0) begin failures++; $display("FAIL f12_addr: bad=%0d required 0", addr_bad()); end
    checks++;
    if (mon_addr.size() < addr_base + 12 || mon_addr[addr_base] !== 11'd1916 || mon_addr[addr_base + 11] !== 11'd1927) begin
      failures++; $display("FAIL f12_addr_range: first=%0d last=%0d required 1916..1927", mon_addr[addr_base], mon_addr[addr_base + 11]);
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < NG; k++) set_rand(k, 1, 94);
    run_frame(30, 1'b0);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL stall_timeout: timed out=%b required 0", tmo); end
    checks++;
    if (mon_px.size() - px_base != 3 * 128) begin
      failures++; $display("FAIL stall_count: writes=%0d required %0d", mon_px.size() - px_base, 3 * 128);
    end
    checks++; if (px_bad() != 0) begin failures++; $display("FAIL stall_pixels: bad=%0d required 0", px_bad()); end
    checks++; if (stall_err != stall_base) begin failures++; $display("FAIL stall_stable: unstable=%0d required 0", stall_err - stall_base); end
    checks++; if (lat_err != lat_base) begin failures++; $display("FAIL stall_done_latency: late=%0d required 0", lat_err - lat_base); end
  endtask

  task automatic test_multi();
    int a0, bad;
    a0 = $urandom_range(0, 94);
    for (int k = 0; k < NG; k++) begin
      g_size[k] = 1'b1; g_ascii[k] = 7'((a0 + 7 * k) % 95);
      g_x[k] = 9'(56 + 8 * k); g_y[k] = 9'd100;
    end
    run_frame(100, 1'b0);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL multi_timeout: timed out=%b required 0", tmo); end
    checks++; if (px_bad() != 0) begin failures++; $display("FAIL multi_pixels: bad=%0d required 0", px_bad()); end
    bad = 0;
    for (int k = 0; k < NG; k++)
      if (done_base + k >= done_px.size() || done_px[done_base + k] != px_base + 128 * (k + 1)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL multi_done_pos: misplaced=%0d required 0", bad); end
    checks++; if (dbl_err != dbl_base) begin failures++; $display("FAIL multi_done_width: long pulses=%0d required 0", dbl_err - dbl_base); end
    checks++; if (bseq !== 3'b110) begin failures++; $display("FAIL multi_busy_fall: busy seq=%b required 110", bseq); end
  endtask

  task automatic test_reset_mid();
    int base, db, t;
    for (int k = 0; k < NG; k++) set_rand(k, 1, 94);
    ready_pct = 100;
    base = mon_px.size(); db = done_cnt;
    @(negedge clk); apply(0); flag = 1'b1;
    @(negedge clk); flag = 1'b0;
    t = 0;
    while (mon_px.size() - base < 128 + 43 && t < 3000) begin @(negedge clk); t++; end
    checks++; if (t >= 3000) begin failures++; $display("FAIL rmid_reach: waited=%0d cycles required under 3000", t); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({wr_bus.wr_req, done, busy} !== 3'b000) begin
      failures++; $display("FAIL rmid_ctrl: req/done/busy=%b required 000", {wr_bus.wr_req, done, busy});
    end
    checks++;
    if ({rom_addr, wr_bus.wr_x, wr_bus.wr_y, wr_bus.wr_color} !== 45'd0) begin
      failures++; $display("FAIL rmid_outputs: addr=%0d x=%0d y=%0d c=%h required 0", rom_addr, wr_bus.wr_x, wr_bus.wr_y, wr_bus.wr_color);
    end
    rst = 1'b0; exp_last_addr = '0;
    repeat (30) @(negedge clk);
    checks++; if (done_cnt - db != 1) begin failures++; $display("FAIL rmid_no_done: pulses=%0d required 1", done_cnt - db); end
    for (int k = 0; k < NG; k++) set_rand(k, -1, 94);
    run_frame(100, 1'b0);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL rmid_timeout: timed out=%b required 0", tmo); end
    checks++; if (px_bad() != 0) begin failures++; $display("FAIL rmid_pixels: bad=%0d required 0", px_bad()); end
    checks++; if (done_cnt - done_base != 3) begin failures++; $display("FAIL rmid_done: pulses=%0d required 3", done_cnt - done_base); end
    checks++; if (bseq !== 3'b110) begin failures++; $display("FAIL rmid_busy_fall: busy seq=%b required 110", bseq); end
  endtask

  task automatic test_blank();
    int nonbg;
    set_rand(0, 1, 94); g_ascii[0] = 7'd127;
    set_rand(1, 0, 94); g_ascii[1] = 7'd100;
    set_rand(2, -1, 94);
    run_frame(100, 1'b1);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL blank_timeout: timed out=%b required 0", tmo); end
    checks++; if (px_bad() != 0) begin failures++; $display("FAIL blank_pixels: bad=%0d required 0", px_bad()); end
    nonbg = 0;
    for (int i = 0; i < 128 + 72 && px_base + i < mon_px.size(); i++)
      if (mon_px[px_base + i].c !== BG) nonbg++;
    checks++; if (nonbg != 0) begin failures++; $display("FAIL blank_colour: non-background=%0d required 0", nonbg); end
    repeat (20) @(negedge clk);
    checks++; if (done_cnt - done_base != 3) begin failures++; $display("FAIL blank_flag_ignored: pulses=%0d required 3", done_cnt - done_base); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL blank_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < NG; k++) set_rand(k, -1, 127);
      run_frame($urandom_range(40, 100), 1'b0);
      checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL b2b_timeout: frame %0d timed out required 0", f); end
      checks++; if (px_bad() != 0) begin failures++; $display("FAIL b2b_pixels: frame %0d bad=%0d required 0", f, px_bad()); end
      checks++; if (addr_bad() != 0) begin failures++; $display("FAIL b2b_addr: frame %0d bad=%0d required 0", f, addr_bad()); end
      checks++; if (stall_err != stall_base) begin failures++; $display("FAIL b2b_stable: frame %0d unstable=%0d required 0", f, stall_err - stall_base); end
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    test_reset();
    test_font16();
    test_font12();
    test_stall();
    test_multi();
    test_reset_mid();
    test_blank();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
